// File: rtl/readout_sequencer.sv
// Bulk readout sequencer: walks channels/registers, strobes each register into the
// serializer and meters NBITS shift cycles. Optional channel skipping: READOUT_CHAN_SKIP_EN.
module readout_sequencer #(
  parameter int NCHAN     = 8,
  parameter int NREG      = 7,
  parameter int NBITS     = 8,
  parameter int BASE_ADDR = 4
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NCHAN-1:0] chan_mask,
  input  logic             out_ready,
  output logic [NCHAN-1:0] load_cnt_ser,
  output logic [2:0]       select_reg,
  output logic             load_strobe,
  output logic             shift_en,
  output logic [5:0]       cur_addr,
  output logic             busy,
  output logic             done
);

  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    chan_reg, chan_next;
  logic [2:0]       sel_reg, sel_next;
  logic [BW-1:0]    bit_reg, bit_next;
  logic [NCHAN-1:0] mask_reg, mask_next;

  logic [NCHAN-1:0] start_mask;
  logic [NCHAN-1:0] active_mask;
  logic [NCHAN-1:0] higher_mask;
  logic             first_found, next_found;
  logic [CW-1:0]    first_idx, next_idx;
  logic             in_reg;

`ifdef READOUT_CHAN_SKIP_EN
  assign start_mask = chan_mask;
`else
  // Without skipping every channel is visited regardless of the requested mask.
  assign start_mask = chan_mask | {NCHAN{1'b1}};
`endif
  assign active_mask = mask_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCHAN; gi++) begin : g_chan
      assign higher_mask[gi]  = active_mask[gi] && (CW'(gi) > chan_reg);
      assign load_cnt_ser[gi] = in_reg && (chan_reg == CW'(gi));
    end
  endgenerate

  // Lowest set bit wins: scan from the top so the last hit is the lowest index.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (start_mask[i]) begin
        first_found = 1'b1;
        first_idx   = CW'(i);
      end
      if (higher_mask[i]) begin
        next_found = 1'b1;
        next_idx   = CW'(i);
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      chan_reg  <= '0;
      sel_reg   <= '0;
      bit_reg   <= '0;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      chan_reg  <= chan_next;
      sel_reg   <= sel_next;
      bit_reg   <= bit_next;
      mask_reg  <= mask_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    chan_next  = chan_reg;
    sel_next   = sel_reg;
    bit_next   = bit_reg;
    mask_next  = mask_reg;
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      chan_next  = '0;
      sel_next   = '0;
      bit_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            mask_next = start_mask;
            sel_next  = '0;
            bit_next  = '0;
            if (first_found) begin
              chan_next  = first_idx;
              state_next = ST_LOAD;
            end else begin
              chan_next  = '0;
              state_next = ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          bit_next   = '0;
          state_next = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (out_ready) begin
            if (bit_reg == BW'(NBITS - 1)) begin
              bit_next = '0;
              if (sel_reg < 3'(NREG - 1)) begin
                sel_next   = sel_reg + 3'd1;
                state_next = ST_LOAD;
              end else if (next_found) begin
                chan_next  = next_idx;
                sel_next   = '0;
                state_next = ST_LOAD;
              end else begin
                state_next = ST_DONE;
              end
            end else begin
              bit_next = bit_reg + BW'(1);
            end
          end
        end
        ST_DONE: begin
          chan_next  = '0;
          sel_next   = '0;
          bit_next   = '0;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign in_reg      = (state_reg == ST_LOAD) || (state_reg == ST_SHIFT);
  assign select_reg  = in_reg ? sel_reg : 3'd0;
  assign cur_addr    = in_reg ? 6'(BASE_ADDR + NREG * int'(chan_reg) + int'(sel_reg)) : 6'd0;
  assign load_strobe = (state_reg == ST_LOAD);
  assign shift_en    = (state_reg == ST_SHIFT) && out_ready;
  assign busy        = (state_reg != ST_IDLE);
  assign done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_readout_sequencer.sv
// Self-checking bench for readout_sequencer: table of readout passes with an
// address scoreboard, plus hand-written abort/reset mid-pass sequences.
module tb_readout_sequencer;

  logic       sclk = 1'b0;
  logic       rst, start, abort, out_ready;
  logic [7:0] chan_mask;
  logic [7:0] load_cnt_ser;
  logic [2:0] select_reg;
  logic       load_strobe, shift_en, busy, done;
  logic [5:0] cur_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  readout_sequencer dut (
    .sclk(sclk), .rst(rst), .start(start), .abort(abort), .chan_mask(chan_mask),
    .out_ready(out_ready), .load_cnt_ser(load_cnt_ser), .select_reg(select_reg),
    .load_strobe(load_strobe), .shift_en(shift_en), .cur_addr(cur_addr),
    .busy(busy), .done(done)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    string      name;
    logic [7:0] mask;
    bit         toggle;
    int         inj_k;
    int         exp_regs;
    int         exp_done_k;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit chan_enabled(input logic [7:0] mask, input int c);
`ifdef READOUT_CHAN_SKIP_EN
    return mask[c];
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_idle_outputs(input string name);
    check({name, "_outs"}, int'({load_cnt_ser, select_reg, load_strobe, shift_en, cur_addr, busy, done}), 0);
  endtask

  task automatic run_pass(input vec_t v);
    int  strobes = 0, shifts = 0, dones = 0, done_k = -1;
    int  budget;
    bit  ph = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 8; c++)
      if (chan_enabled(v.mask, c))
        for (int r = 0; r < 7; r++) exp_q.push_back(4 + 7 * c + r);
    budget = v.exp_done_k + 40;
    out_ready = 1'b1;
    start = 1'b1;
    chan_mask = v.mask;
    @(posedge sclk);
    for (int k = 1; k <= budget; k++) begin
      if (k > 1) @(posedge sclk);
      #1;
      if (k == 1) start = 1'b0;
      if (k == v.inj_k) begin
        start = 1'b1;
        chan_mask = 8'h5A;
      end else if (k == v.inj_k + 1) begin
        start = 1'b0;
      end
      if (v.toggle) begin
        if (load_strobe) begin
          ph = 1'b0;
          out_ready = 1'b0;
        end else begin
          out_ready = ph;
          ph = ~ph;
        end
      end
      #1;
      if (shift_en) shifts++;
      if (load_strobe) begin
        strobes++;
        if (exp_q.size() == 0) begin
          check({v.name, "_extra_strobe"}, int'(cur_addr), -1);
        end else begin
          int a = exp_q.pop_front();
          check({v.name, "_cur_addr"}, int'(cur_addr), a);
          check({v.name, "_select_reg"}, int'(select_reg), (a - 4) % 7);
          check({v.name, "_load_cnt_ser"}, int'(load_cnt_ser), 1 << ((a - 4) / 7));
        end
      end
      if (done) begin
        dones++;
        done_k = k;
        check({v.name, "_done_outs"}, int'({load_cnt_ser, cur_addr, load_strobe, shift_en}), 0);
        break;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (done_k < 0) check({v.name, "_done_timeout"}, 0, 1);
    for (int j = 0; j < 3; j++) begin
      @(posedge sclk);
      #2;
      if (done) dones++;
      check({v.name, "_post_busy_strobe"}, int'({busy, load_strobe}), 0);
    end
    check({v.name, "_done_cycle"}, done_k, v.exp_done_k);
    check({v.name, "_done_count"}, dones, 1);
    check({v.name, "_strobes"}, strobes, v.exp_regs);
    check({v.name, "_shifts"}, shifts, 8 * v.exp_regs);
    check({v.name, "_queue_left"}, exp_q.size(), 0);
    $display("pass %s mask=%02h regs=%0d done_k=%0d", v.name, v.mask, strobes, done_k);
  endtask

  task automatic cancel_test(input bit use_rst);
    string nm = use_rst ? "rst_mid" : "abort_mid";
    bit found = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    chan_mask = 8'hFF;
    @(posedge sclk);
    for (int k = 1; k <= 400; k++) begin
      if (k > 1) @(posedge sclk);
      #1;
      start = 1'b0;
      #1;
      if (load_strobe && cur_addr == 6'd21) begin
        found = 1'b1;
        break;
      end
    end
    check({nm, "_reach_ch2_sel3"}, int'(found), 1);
    if (use_rst) rst = 1'b1;
    else abort = 1'b1;
    @(posedge sclk);
    #1;
    rst = 1'b0;
    abort = 1'b0;
    #1;
    check_idle_outputs(nm);
    @(posedge sclk);
    #2;
    check({nm, "_no_done"}, int'({busy, done}), 0);
    $display("cancel %s addr_seen=%0d", nm, found);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"full",     8'hFF, 1'b0, 0,  56, 505};
`ifdef READOUT_CHAN_SKIP_EN
    vecs[1] = '{"skip12",   8'h12, 1'b0, 0,  14, 127};
    vecs[2] = '{"empty",    8'h00, 1'b0, 0,  0,  1};
    vecs[3] = '{"skip81_bp", 8'h81, 1'b1, 0, 14, 239};
`else
    vecs[1] = '{"skip12",   8'h12, 1'b0, 0,  56, 505};
    vecs[2] = '{"empty",    8'h00, 1'b0, 0,  56, 505};
    vecs[3] = '{"skip81_bp", 8'h81, 1'b1, 0, 56, 953};
`endif
    vecs[4] = '{"bp_full",  8'hFF, 1'b1, 0,  56, 953};
    vecs[5] = '{"busy_start", 8'hFF, 1'b0, 30, 56, 505};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    chan_mask = 8'h00;
    repeat (3) @(posedge sclk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    #1;

    for (int i = 0; i < 6; i++) run_pass(vecs[i]);

    cancel_test(1'b0);
    run_pass(vecs[0]);
    cancel_test(1'b1);
    run_pass(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
